// File: rtl/sequential_divider.sv
// Multi-cycle restoring unsigned divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional early-out for dividend < divisor is enabled by defining SEQDIV_EARLY_OUT_EN.
module sequential_divider #(
  parameter int NUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*NUM_BITS-1:0] dividend,
  input  logic [NUM_BITS-1:0]   divisor,
  output logic [2*NUM_BITS-1:0] quotient,
  output logic [NUM_BITS-1:0]   remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int unsigned QW = 2 * NUM_BITS;
  localparam int unsigned CW = $clog2(QW + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(QW);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] divisor_q, divisor_d;
  logic [QW-1:0]       w_q, w_d;
  logic [NUM_BITS-1:0] r_q, r_d;
  logic [CW-1:0]       count_q, count_d;
  logic [QW-1:0]       quotient_q, quotient_d;
  logic [NUM_BITS-1:0] remainder_q, remainder_d;
  logic                div_by_zero_q, div_by_zero_d;

  logic [NUM_BITS:0]   trial;
  logic [NUM_BITS-1:0] trial_diff;
  logic [NUM_BITS-1:0] r_next;
  logic                q_bit;
  logic                early_out;

`ifdef SEQDIV_EARLY_OUT_EN
  assign early_out = (dividend < {{NUM_BITS{1'b0}}, divisor});
`else
  assign early_out = 1'b0;
`endif

  // The partial remainder is stored N bits wide: after every restoring step R < divisor,
  // so bit N of R is always zero and only the trial value needs the extra bit.
  // The N-bit subtraction is exact whenever the trial is accepted (result < divisor).
  always_comb begin
    trial      = {r_q, w_q[QW-1]};
    q_bit      = (trial >= {1'b0, divisor_q});
    trial_diff = trial[NUM_BITS-1:0] - divisor_q;
    r_next     = q_bit ? trial_diff : trial[NUM_BITS-1:0];
  end

  always_comb begin
    state_d       = state_q;
    divisor_d     = divisor_q;
    w_d           = w_q;
    r_d           = r_q;
    count_d       = count_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d    = '1;
            remainder_d   = '0;
            div_by_zero_d = 1'b1;
            state_d       = DONE;
          end else if (early_out) begin
            quotient_d    = '0;
            remainder_d   = dividend[NUM_BITS-1:0];
            div_by_zero_d = 1'b0;
            state_d       = DONE;
          end else begin
            divisor_d = divisor;
            w_d       = dividend;
            r_d       = '0;
            count_d   = COUNT_INIT;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        r_d     = r_next;
        w_d     = {w_q[QW-2:0], q_bit};
        count_d = count_q - COUNT_LAST;
        if (count_q == COUNT_LAST) begin
          quotient_d    = {w_q[QW-2:0], q_bit};
          remainder_d   = r_next;
          div_by_zero_d = 1'b0;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      divisor_q     <= '0;
      w_q           <= '0;
      r_q           <= '0;
      count_q       <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      divisor_q     <= divisor_d;
      w_q           <= w_d;
      r_q           <= r_d;
      count_q       <= count_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: vector table, hand-written control sequences,
// and random operands checked against plain integer division.
module tb_sequential_divider;

  localparam int N  = 4;
  localparam int QW = 2 * N;
  localparam int LIMIT = 4 * QW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [QW-1:0] dividend;
  logic [N-1:0]  divisor;
  logic [QW-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequential_divider #(.NUM_BITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [QW-1:0] dd;
    logic [N-1:0]  dv;
    logic [QW-1:0] q;
    logic [N-1:0]  r;
    logic          dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [QW-1:0] dd, input logic [N-1:0] dv);
    if (dv == '0) return 1;
`ifdef SEQDIV_EARLY_OUT_EN
    if (dd < {{N{1'b0}}, dv}) return 1;
`endif
    return QW + 1;
  endfunction

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [QW-1:0] dd, input logic [N-1:0] dv,
                        input logic [QW-1:0] eq, input logic [N-1:0] er, input logic edz,
                        input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < LIMIT) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, lat, exp_lat(dd, dv));
    check({tag, " busy_cycles"}, bcnt, (exp_lat(dd, dv) == 1) ? 0 : QW);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edz);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " idle_after"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int dcnt;
    logic [QW-1:0] dd;
    logic [N-1:0]  dv;
    logic [QW-1:0] eq;
    logic [N-1:0]  er;
    logic          edz;

    vecs[0]  = '{8'd195, 4'd13, 8'd15,  4'd0,  1'b0};
    vecs[1]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    vecs[2]  = '{8'd100, 4'd0,  8'd255, 4'd0,  1'b1};
    vecs[3]  = '{8'd126, 4'd9,  8'd14,  4'd0,  1'b0};
    vecs[4]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vecs[5]  = '{8'd52,  4'd4,  8'd13,  4'd0,  1'b0};
    vecs[6]  = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
    vecs[7]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
    vecs[8]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    vecs[9]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
    vecs[10] = '{8'd9,   4'd9,  8'd1,   4'd0,  1'b0};
    vecs[11] = '{8'd0,   4'd0,  8'd255, 4'd0,  1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_by_zero", div_by_zero, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));
    end

    // Results hold across idle cycles
    run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, "hold_setup");
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("hold done_pulses", dcnt, 0);
    check("hold quotient", quotient, 28);
    check("hold remainder", remainder, 4);

    // start held high and operands scrambled while busy
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    lat  = 1;
    dcnt = 0;
    while (!done && lat < LIMIT) begin
      dividend = QW'($urandom);
      divisor  = N'($urandom);
      @(negedge clk);
      lat++;
    end
    check("held_start done", done, 1);
    check("held_start latency", lat, QW + 1);
    check("held_start quotient", quotient, 255);
    check("held_start remainder", remainder, 0);
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge clk);
    check("held_start ignored_in_done busy", busy, 0);
    check("held_start ignored_in_done done", done, 0);
    @(negedge clk);
    start = 1'b0;
    check("held_start accepted_in_idle", busy, 1);
    wait_done(lat);
    check("held_start second done", done, 1);
    check("held_start second quotient", quotient, 28);
    check("held_start second remainder", remainder, 4);
    @(negedge clk);
    check("held_start second done_one_cycle", done, 0);

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    dividend = 8'd195;
    divisor  = 4'd13;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst div_by_zero", div_by_zero, 0);
    dcnt = 0;
    repeat (QW + 2) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst stays_idle", dcnt, 0);
    run_op(8'd52, 4'd4, 8'd13, 4'd0, 1'b0, "after_rst");

    // Random operands against integer division
    for (int i = 0; i < 150; i++) begin
      dd = QW'($urandom);
      if ((i % 4) == 0) dd = QW'($urandom_range(0, 20));
      dv = N'($urandom_range(0, (1 << N) - 1));
      if (dv == '0) begin
        eq  = '1;
        er  = '0;
        edz = 1'b1;
      end else begin
        eq  = QW'(int'(dd) / int'(dv));
        er  = N'(int'(dd) % int'(dv));
        edz = 1'b0;
      end
      run_op(dd, dv, eq, er, edz, $sformatf("rand%0d %0d/%0d", i, dd, dv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
